// File: rtl/round_key_sequencer.sv
// round_key_sequencer
// AddRoundKey engine for an iterative block cipher. Holds NR+1 round keys and
// XORs the correct key into the cipher state on every round, in forward order
// for encryption and reverse order for decryption.
//
// Handshakes: every channel (in, out, fb) transfers on a cycle where its
// valid and ready are both high; a valid may be presented at any time, and
// ready never depends on the same channel's valid.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   key_wr_*          round-key load port (IDLE only, idx 0..NR)
//   key_wr_err        one-cycle pulse after a rejected key write
//   keys_ready        every key slot loaded since reset (sticky)
//   in_*              block input channel; in_decrypt selects key order
//   out_*             keyed state output with its round number and last flag
//   fb_*              state returned from the external round function
//   dbg_state         current FSM state (0 IDLE, 1 OUT, 2 FB)
module round_key_sequencer #(
  parameter  int DATA_W = 128,
  parameter  int NR     = 10,
  localparam int IDX_W  = $clog2(NR + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  output logic              key_wr_err,
  output logic              keys_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_decrypt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_round,
  output logic              out_last,
  input  logic              fb_valid,
  output logic              fb_ready,
  input  logic [DATA_W-1:0] fb_data,
  output logic [1:0]        dbg_state
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OUT  = 2'd1,
    S_FB   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   key_mem [NR+1];
  logic [NR:0]         loaded_q;
  logic                decrypt_q;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]    out_round_q, out_round_d;
  logic                key_wr_err_q;
  logic                accept, fb_fire, wr_ok;
  logic [IDX_W-1:0]    rd_idx;
  logic [DATA_W-1:0]   rd_key;

  // Decryption walks the key schedule backwards.
  function automatic logic [IDX_W-1:0] key_idx(input logic dec, input logic [IDX_W-1:0] rnd);
    return dec ? (LAST - rnd) : rnd;
  endfunction

  assign keys_ready = &loaded_q;
  assign accept     = (state_q == S_IDLE) & keys_ready & in_valid;
  assign fb_fire    = (state_q == S_FB) & fb_valid;
  assign wr_ok      = (state_q == S_IDLE) & (key_wr_idx <= LAST);

  // In IDLE the key for round 0 uses the mode being offered right now; in FB
  // the latched mode selects the key of the next round.
  always_comb begin
    rd_idx = '0;
    if (state_q == S_IDLE) rd_idx = key_idx(in_decrypt, '0);
    else                   rd_idx = key_idx(decrypt_q, out_round_q + 1'b1);
    rd_key = key_mem[rd_idx];
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = out_last ? S_IDLE : S_FB;
      S_FB:    if (fb_valid) state_d = S_OUT;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state_q == S_IDLE) & keys_ready;
    out_valid = (state_q == S_OUT);
    fb_ready  = (state_q == S_FB);
    dbg_state = state_q;
  end

  // ---------------- datapath ----------------
  always_comb begin
    out_data_d  = out_data_q;
    out_round_d = out_round_q;
    if (accept) begin
      out_data_d  = in_data ^ rd_key;
      out_round_d = '0;
    end else if (fb_fire) begin
      out_data_d  = fb_data ^ rd_key;
      out_round_d = out_round_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_q   <= '0;
      out_round_q  <= '0;
      decrypt_q    <= 1'b0;
      loaded_q     <= '0;
      key_wr_err_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_round_q  <= out_round_d;
      if (accept) decrypt_q <= in_decrypt;
      if (key_wr_en && wr_ok) loaded_q[key_wr_idx] <= 1'b1;
      key_wr_err_q <= key_wr_en & ~wr_ok;
    end
  end

  // Key storage is deliberately not reset; the loaded bitmap tracks validity.
  // A write coinciding with an accept lands after the accept has read the key.
  always_ff @(posedge clk) begin
    if (key_wr_en && wr_ok) key_mem[key_wr_idx] <= key_wr_data;
  end

  assign out_data   = out_data_q;
  assign out_round  = out_round_q;
  assign out_last   = (out_round_q == LAST);
  assign key_wr_err = key_wr_err_q;

endmodule

// File: tb/tb_round_key_sequencer.sv
module tb_round_key_sequencer;
  localparam int W  = 128;
  localparam int NR = 10;
  localparam int IW = $clog2(NR + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          key_wr_en = 0, key_wr_err, keys_ready;
  logic [IW-1:0] key_wr_idx = '0;
  logic [W-1:0]  key_wr_data = '0;
  logic          in_valid = 0, in_ready, in_decrypt = 0;
  logic [W-1:0]  in_data = '0;
  logic          out_valid, out_ready = 0, out_last;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_round;
  logic          fb_valid = 0, fb_ready;
  logic [W-1:0]  fb_data = '0;
  logic [1:0]    dbg_state;

  round_key_sequencer #(.DATA_W(W), .NR(NR)) dut (
    .clk(clk), .reset(reset),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .key_wr_err(key_wr_err), .keys_ready(keys_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_round(out_round), .out_last(out_last),
    .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_data(fb_data),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0]  key_m [NR+1];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  obs_data_q[$];
  logic [IW-1:0] obs_round_q[$];
  logic          obs_last_q[$];
  logic [W-1:0]  fb_q[$];
  bit timed_out, aborted, err1, err2, fbr_during;
  int first_lat, stall_same;

  function automatic logic [W-1:0] rand_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: round r keys with slot r (encrypt) or NR-r (decrypt);
  // round 0 keys the input block, later rounds key whatever came back on fb.
  task automatic model_block(input logic [W-1:0] din, input bit dec, input bit echo);
    logic [W-1:0] st, e;
    exp_q.delete();
    st = din;
    for (int r = 0; r <= NR; r++) begin
      e = st ^ key_m[dec ? NR - r : r];
      exp_q.push_back(e);
      if (r < NR) st = echo ? e : fb_q[r];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_key(input int idx, input logic [W-1:0] d);
    key_wr_en = 1; key_wr_idx = idx[IW-1:0]; key_wr_data = d;
    tick();
    key_wr_en = 0;
    if (idx <= NR) key_m[idx] = d;
  endtask

  // Runs one block through the DUT. Optional hooks: stall_rnd holds out_ready
  // low for 5 cycles at that round (with stray in_valid/fb_valid); badw_rnd
  // issues a key write while in FB; abort_rnd returns early in FB; cw writes
  // slot 0 in the same cycle as the accept.
  task automatic drive_block(input logic [W-1:0] din, input bit dec, input bit echo,
                             input int stall_rnd, input int badw_rnd, input int abort_rnd,
                             input bit cw, input logic [W-1:0] cw_data);
    int n;
    logic [W-1:0] hold_d, fbv;
    logic [IW-1:0] hold_r;
    obs_data_q.delete(); obs_round_q.delete(); obs_last_q.delete(); fb_q.delete();
    timed_out = 0; aborted = 0; first_lat = -1; stall_same = 0;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin timed_out = 1; return; end
    in_valid = 1; in_data = din; in_decrypt = dec;
    if (cw) begin key_wr_en = 1; key_wr_idx = '0; key_wr_data = cw_data; end
    tick();
    in_valid = 0; key_wr_en = 0; in_data = rand_w(); in_decrypt = ~dec;
    for (int r = 0; r <= NR; r++) begin
      n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
      if (r == 0) first_lat = n;
      if (!out_valid) begin timed_out = 1; return; end
      if (r == stall_rnd) begin
        hold_d = out_data; hold_r = out_round;
        fb_valid = 1; fb_data = rand_w(); in_valid = 1;
        repeat (5) begin
          tick();
          if (out_valid && out_data === hold_d && out_round === hold_r) stall_same++;
        end
        fb_valid = 0; in_valid = 0;
      end else begin
        repeat ($urandom_range(0, 2)) tick();
      end
      obs_data_q.push_back(out_data);
      obs_round_q.push_back(out_round);
      obs_last_q.push_back(out_last);
      out_ready = 1;
      tick();
      out_ready = 0;
      if (r == NR) break;
      n = 0;
      while (!fb_ready && n < 50) begin tick(); n++; end
      if (!fb_ready) begin timed_out = 1; return; end
      if (r == abort_rnd) begin aborted = 1; return; end
      if (r == badw_rnd) begin
        key_wr_en = 1; key_wr_idx = IW'(3); key_wr_data = rand_w(); in_valid = 1;
        tick();
        key_wr_en = 0; in_valid = 0;
        err1 = key_wr_err; fbr_during = fb_ready;
        tick();
        err2 = key_wr_err;
      end
      repeat ($urandom_range(0, 2)) tick();
      fbv = echo ? obs_data_q[r] : rand_w();
      fb_q.push_back(fbv);
      fb_valid = 1; fb_data = fbv;
      tick();
      fb_valid = 0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    checks++; if (out_round !== '0) begin errors++; $display("FAIL rst_out_round: got %0d want 0", out_round); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    checks++; if (key_wr_err !== 1'b0) begin errors++; $display("FAIL rst_key_wr_err: got %b want 0", key_wr_err); end
    checks++; if (keys_ready !== 1'b0) begin errors++; $display("FAIL rst_keys_ready: got %b want 0", keys_ready); end
    checks++; if (fb_ready !== 1'b0) begin errors++; $display("FAIL rst_fb_ready: got %b want 0", fb_ready); end
    reset = 1;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_key_load();
    for (int i = 0; i < NR; i++) write_key(i, {16{i[7:0]}});
    checks++; if (keys_ready !== 1'b0) begin errors++; $display("FAIL partial_keys_ready: got %b want 0", keys_ready); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL partial_in_ready: got %b want 0", in_ready); end
    write_key(NR, {16{8'h0a}});
    checks++; if (keys_ready !== 1'b1) begin errors++; $display("FAIL full_keys_ready: got %b want 1", keys_ready); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready: got %b want 1", in_ready); end
    checks++; if (key_wr_err !== 1'b0) begin errors++; $display("FAIL legal_write_err: got %b want 0", key_wr_err); end
  endtask

  task automatic test_fips_round0();
    logic [W-1:0] saved;
    saved = key_m[0];
    write_key(0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    drive_block(128'h3243f6a8885a308d313198a2e0370734, 0, 0, -1, -1, -1, 0, '0);
    model_block(128'h3243f6a8885a308d313198a2e0370734, 0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL fips_timeout: got timeout want completion"); end
    checks++; if (first_lat !== 0) begin errors++; $display("FAIL fips_latency: got %0d extra cycles want 0", first_lat); end
    if (obs_data_q.size() > 0) begin
      checks++; if (obs_data_q[0] !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin errors++; $display("FAIL fips_round0: got %h want 193de3bea0f4e22b9ac68d2ae9f84808", obs_data_q[0]); end
      checks++; if (obs_round_q[0] !== '0) begin errors++; $display("FAIL fips_round_num: got %0d want 0", obs_round_q[0]); end
    end
    for (int r = 1; r < obs_data_q.size(); r++) begin
      checks++; if (obs_data_q[r] !== exp_q[r]) begin errors++; $display("FAIL fips_block r%0d: got %h want %h", r, obs_data_q[r], exp_q[r]); end
    end
    write_key(0, saved);
  endtask

  task automatic test_encrypt_full();
    logic [W-1:0] din;
    din = rand_w();
    drive_block(din, 0, 1, -1, -1, -1, 0, '0);
    model_block(din, 0, 1);
    checks++; if (timed_out || obs_data_q.size() != NR + 1) begin errors++; $display("FAIL enc_count: got %0d outputs want %0d", obs_data_q.size(), NR + 1); end
    for (int r = 0; r < obs_data_q.size(); r++) begin
      checks++;
      if (obs_data_q[r] !== exp_q[r] || obs_round_q[r] !== r[IW-1:0] || obs_last_q[r] !== (r == NR)) begin
        errors++; $display("FAIL enc_round r%0d: got %h/%0d/%b want %h/%0d/%b", r, obs_data_q[r], obs_round_q[r], obs_last_q[r], exp_q[r], r, (r == NR));
      end
    end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL enc_back_idle: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_decrypt();
    drive_block('0, 1, 1, -1, -1, -1, 0, '0);
    model_block('0, 1, 1);
    checks++; if (timed_out || obs_data_q.size() != NR + 1) begin errors++; $display("FAIL dec_count: got %0d outputs want %0d", obs_data_q.size(), NR + 1); end
    if (obs_data_q.size() > 1) begin
      checks++; if (obs_data_q[0] !== {16{8'h0a}}) begin errors++; $display("FAIL dec_round0: got %h want %h", obs_data_q[0], {16{8'h0a}}); end
      checks++; if (obs_data_q[1] !== {16{8'h03}}) begin errors++; $display("FAIL dec_round1: got %h want %h", obs_data_q[1], {16{8'h03}}); end
    end
    for (int r = 0; r < obs_data_q.size(); r++) begin
      checks++; if (obs_data_q[r] !== exp_q[r] || obs_round_q[r] !== r[IW-1:0]) begin errors++; $display("FAIL dec_round r%0d: got %h/%0d want %h/%0d", r, obs_data_q[r], obs_round_q[r], exp_q[r], r); end
    end
  endtask

  task automatic test_backpressure_illegal();
    logic [W-1:0] din;
    din = rand_w();
    err1 = 0; err2 = 1; fbr_during = 0;
    drive_block(din, 0, 0, 2, 1, -1, 0, '0);
    model_block(din, 0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: got timeout want completion"); end
    checks++; if (stall_same !== 5) begin errors++; $display("FAIL bp_stable: got %0d stable cycles want 5", stall_same); end
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL fb_write_err: got %b want 1", err1); end
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL fb_write_err_pulse: got %b want 0", err2); end
    checks++; if (fbr_during !== 1'b1) begin errors++; $display("FAIL fb_hold_state: got fb_ready=%b want 1", fbr_during); end
    for (int r = 0; r < obs_data_q.size(); r++) begin
      checks++; if (obs_data_q[r] !== exp_q[r]) begin errors++; $display("FAIL bp_round r%0d: got %h want %h", r, obs_data_q[r], exp_q[r]); end
    end
    key_wr_en = 1; key_wr_idx = IW'(NR + 1); key_wr_data = rand_w();
    tick();
    key_wr_en = 0;
    checks++; if (key_wr_err !== 1'b1) begin errors++; $display("FAIL idx_err: got %b want 1", key_wr_err); end
    tick();
    checks++; if (key_wr_err !== 1'b0) begin errors++; $display("FAIL idx_err_pulse: got %b want 0", key_wr_err); end
    checks++; if (keys_ready !== 1'b1) begin errors++; $display("FAIL idx_keys_ready: got %b want 1", keys_ready); end
  endtask

  task automatic test_write_at_accept();
    logic [W-1:0] din, nk;
    din = rand_w(); nk = rand_w();
    drive_block(din, 0, 1, -1, -1, -1, 1, nk);
    model_block(din, 0, 1);
    key_m[0] = nk;
    checks++; if (timed_out || obs_data_q.size() != NR + 1) begin errors++; $display("FAIL cw_count: got %0d outputs want %0d", obs_data_q.size(), NR + 1); end
    for (int r = 0; r < obs_data_q.size(); r++) begin
      checks++; if (obs_data_q[r] !== exp_q[r]) begin errors++; $display("FAIL cw_round r%0d: got %h want %h", r, obs_data_q[r], exp_q[r]); end
    end
  endtask

  task automatic test_random_blocks();
    logic [W-1:0] din;
    bit dec, echo;
    for (int b = 0; b < 8; b++) begin
      write_key($urandom_range(0, NR), rand_w());
      din = rand_w(); dec = 1'($urandom_range(0, 1)); echo = 1'($urandom_range(0, 1));
      drive_block(din, dec, echo, -1, -1, -1, 0, '0);
      model_block(din, dec, echo);
      checks++; if (timed_out || obs_data_q.size() != NR + 1) begin errors++; $display("FAIL rnd_count b%0d: got %0d outputs want %0d", b, obs_data_q.size(), NR + 1); end
      for (int r = 0; r < obs_data_q.size(); r++) begin
        checks++;
        if (obs_data_q[r] !== exp_q[r] || obs_round_q[r] !== r[IW-1:0] || obs_last_q[r] !== (r == NR)) begin
          errors++; $display("FAIL rnd b%0d r%0d dec=%0d: got %h want %h", b, r, dec, obs_data_q[r], exp_q[r]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_block();
    logic [W-1:0] din;
    drive_block(rand_w(), 0, 0, -1, -1, 4, 0, '0);
    checks++; if (!aborted || fb_ready !== 1'b1 || out_round !== IW'(4)) begin errors++; $display("FAIL mid_precond: got aborted=%b fb_ready=%b round=%0d want 1/1/4", aborted, fb_ready, out_round); end
    reset = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_round !== '0 || out_last !== 1'b0) begin errors++; $display("FAIL mid_rst_out: got v=%b d=%h r=%0d l=%b want all 0", out_valid, out_data, out_round, out_last); end
    checks++; if (fb_ready !== 1'b0 || keys_ready !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl: got fb=%b kr=%b ir=%b want 0/0/0", fb_ready, keys_ready, in_ready); end
    tick();
    reset = 1;
    repeat (3) tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_after_rel: got in_ready=%b want 0", in_ready); end
    for (int i = 0; i < NR; i++) write_key(i, rand_w());
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_partial: got in_ready=%b want 0", in_ready); end
    write_key(NR, rand_w());
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reloaded: got in_ready=%b want 1", in_ready); end
    din = rand_w();
    drive_block(din, 1, 1, -1, -1, -1, 0, '0);
    model_block(din, 1, 1);
    checks++; if (timed_out || obs_data_q.size() != NR + 1) begin errors++; $display("FAIL mid_block_count: got %0d outputs want %0d", obs_data_q.size(), NR + 1); end
    for (int r = 0; r < obs_data_q.size(); r++) begin
      checks++; if (obs_data_q[r] !== exp_q[r]) begin errors++; $display("FAIL mid_block r%0d: got %h want %h", r, obs_data_q[r], exp_q[r]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_key_load();
    test_fips_round0();
    test_encrypt_full();
    test_decrypt();
    test_backpressure_illegal();
    test_write_at_accept();
    test_random_blocks();
    test_reset_mid_block();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_key_sequencer.md
Name: round_key_sequencer

Overview:
- Parametrised AddRoundKey engine for the iterative cipher core: holds all NR+1 round keys and applies the correct key to the cipher state on every round.
- Round index and encrypt/decrypt key ordering are tracked internally.
- Sits between the cipher-core input register and the external round-function loop (SubBytes/ShiftRows/MixColumns), which it drives through valid/ready handshakes.

Parameters:
DATA_W, 128, width of state and of each round key in bits
NR, 10, number of cipher rounds; legal values 10/12/14; key store depth NR+1
IDX_W, $clog2(NR+1), width of round and key indices (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
key_wr_en  in  1  write one round key this cycle
key_wr_idx  in  IDX_W  round-key slot to write
key_wr_data  in  DATA_W  round-key value
key_wr_err  out  1  one-cycle pulse: write rejected
keys_ready  out  1  all NR+1 slots written since reset
in_valid  in  1  new block offered
in_ready  out  1  block accepted when in_valid & in_ready
in_data  in  DATA_W  plaintext/ciphertext block
in_decrypt  in  1  sampled with in_data; 1 = reverse key order
out_valid  out  1  keyed state available
out_ready  in  1  consumer accepts out_data
out_data  out  DATA_W  state XOR round key
out_round  out  IDX_W  round number 0..NR of out_data
out_last  out  1  out_round == NR
fb_valid  in  1  round-function result offered
fb_ready  out  1  sequencer waiting for feedback
fb_data  in  DATA_W  state returned from round function

Behaviour:
- Reset (async, active-low) values: state IDLE; out_valid, out_data, out_round, out_last, key_wr_err, keys_ready, fb_ready all 0; loaded bitmap cleared. Key storage is not reset.
- Key index for round r: r when encrypting, NR-r when decrypting. Mode is latched at accept and held for the whole block.
- FSM states: IDLE, OUT, FB.
- IDLE:
  - in_ready = keys_ready.
  - On accept: out_data <= in_data ^ key[idx(0)]; out_round <= 0; out_valid = 1 next cycle; state goes to OUT.
  - Latency: accept at cycle N, out_valid at N+1.
- OUT:
  - out_data, out_round and out_last are held stable until out_valid & out_ready.
  - On that handshake: if out_last, go to IDLE (in_ready may rise next cycle); otherwise go to FB.
- FB:
  - fb_ready = 1.
  - On fb_valid: out_data <= fb_data ^ key[idx(round+1)]; round increments; go to OUT.
  - No timeout: FB waits indefinitely.
- out_last = (out_round == NR). Exactly NR+1 outputs are produced per block.
- Key writes:
  - Accepted only in IDLE with key_wr_idx <= NR. An accepted write sets that slot's loaded bit.
  - A write in OUT/FB, or with idx > NR, is dropped and pulses key_wr_err the next cycle.
  - If an IDLE write coincides with an accept, the accept uses the old key value (write takes effect next cycle).
- keys_ready = AND of the loaded bits. Once set, it stays set until reset.
- Ports are strictly one-hot by state: in_valid in OUT/FB, and fb_valid outside FB, are ignored (no state change).
- Reset mid-block aborts immediately; no partial output is retained.
- The XOR is full width, bitwise, with no carries. DATA_W need not be 128; the same rules apply.

Test Plan:
- Key-load gating: write slots 0..NR-1 only -> keys_ready=0, in_ready=0; write slot NR -> keys_ready=1 next cycle.
- FIPS-197 round 0 (encrypt): key[0]=2b7e151628aed2a6abf7158809cf4f3c, in_data=3243f6a8885a308d313198a2e0370734, in_decrypt=0 -> out_data=193de3bea0f4e22b9ac68d2ae9f84808, out_round=0, out_valid at N+1.
- Full encrypt pass, NR=10: keys key[i]={16{8'hi}}, fb_data echoes out_data -> 11 outputs, rounds 0..10, out_last only on round 10, then in_ready=1.
- Decrypt ordering: same keys, in_decrypt=1, in_data=0 -> round-0 out_data=key[10]; round-1 out_data=key[10]^key[9] (fb echo).
- Backpressure and illegal writes: hold out_ready=0 for 5 cycles -> out_data/out_round stable. key_wr_en during FB -> key_wr_err 1-cycle pulse, key unchanged. key_wr_idx=NR+1 in IDLE -> key_wr_err pulse.
- Reset mid-block: assert reset in FB at round 4 -> all outputs 0 asynchronously, keys_ready=0. After release, in_ready stays 0 until all keys are reloaded.
